nim_board_ctrl: RTL and testbench
=================================

// Module: nim_board_ctrl
// PURPOSE
//  Parametrised board/turn controller for the two-player pile game. Holds CELLS piles of
//  VAL_W bits, drives cursor selection, edit and commit from decoded PS2 key strobes,
//  alternates players and detects game over. Feeds the display (board, cursor, edit
//  value) and the buzzer (commit/game-over pulses); replaces the ad-hoc top-level commit logic.
// PARAMETERS
//  CELLS     10  number of piles on the board (>=2)
//  VAL_W     4   bits per pile value
//  INIT_VAL  1   value loaded into every active pile at game start (1..2^VAL_W-1)
//  IDX_W     $clog2(CELLS)  cursor width (derived, not overridden)
// PORTS
//  clk          in   1             system clock
//  rst_n        in   1             asynchronous active-low reset
//  key_up       in   1             up key, level or pulse
//  key_down     in   1             down key
//  key_left     in   1             left key
//  key_right    in   1             right key
//  key_enter    in   1             enter key: start / select / cancel / restart
//  key_space    in   1             space key: commit edit
//  active_cnt   in   IDX_W+1       piles in play, sampled at game start
//  board        out  CELLS*VAL_W   pile values, pile i at [i*VAL_W +: VAL_W]
//  cursor       out  IDX_W         selected pile index
//  edit_val     out  VAL_W         pending new value for selected pile
//  player       out  1             player to move (0/1)
//  state        out  3             IDLE=0 SELECT=1 EDIT=2 COMMIT=3 OVER=4
//  commit_pulse out  1             1-cycle strobe when a move is written
//  game_over    out  1             high while in OVER
//  winner       out  1             player who made the last move; valid in OVER
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, board=0, cursor=0, edit_val=0, player=0,
//    commit_pulse=0, game_over=0, winner=0, edge registers=0. All outputs registered.
//  - Keys: rising-edge detected internally (1-cycle delayed previous sample); a held key
//    acts once. Action occurs the cycle after the rising edge is sampled.
//  - Same-cycle edges: priority space > enter > left/right > up/down; only one acts.
//    left+right together, or up+down together, is a no-op.
//  - IDLE: enter -> load n=clamp(active_cnt,1,CELLS); piles 0..n-1 = INIT_VAL, others 0;
//    cursor=0, player=0, winner=0 -> SELECT. Other keys ignored.
//  - SELECT: right: cursor+1, wraps n-1 -> 0; left: cursor-1, wraps 0 -> n-1.
//    enter on pile with value>0: edit_val=value-1 -> EDIT. enter on empty pile: ignored.
//    up/down/space ignored.
//  - EDIT: down: edit_val-1, saturates at 0; up: edit_val+1, saturates at board[cursor]-1
//    (a move must strictly reduce the pile). space -> COMMIT. enter: cancel -> SELECT,
//    board unchanged. left/right ignored.
//  - COMMIT (exactly 1 cycle, keys ignored): board[cursor]<=edit_val, commit_pulse=1,
//    player toggles. If all piles are 0 after the write: winner=mover, -> OVER; else
//    -> SELECT, cursor unchanged.
//  - OVER: game_over=1, board frozen; enter -> IDLE (board kept until next start).
//  - n latched at start; active_cnt changes mid-game have no effect.
//  - Unused encodings 5..7 of state recover to IDLE next cycle.
//  - rst_n asserted mid-game: immediate return to reset values, no commit_pulse.
// TESTING
//  1 Reset, active_cnt=3, INIT_VAL=1, enter -> state=SELECT, board piles 0..2=1, rest 0, cursor=0.
//  2 SELECT n=3: left from cursor 0 -> 2; right from 2 -> 0; key held 100 cycles moves once.
//  3 INIT_VAL=5: enter on pile 1 -> edit_val=4; up x3 -> 4; down x6 -> 0; space -> pile1=0,
//    commit_pulse 1 cycle, player 0->1.
//  4 EDIT enter cancel -> SELECT, board unchanged, player unchanged; enter on empty pile ignored.
//  5 n=2, INIT_VAL=1: P0 clears pile0, P1 clears pile1 -> OVER, game_over=1, winner=1;
//    enter -> IDLE.
//  6 space+enter same edge in EDIT -> commit only; rst_n low during EDIT -> all outputs reset.

Source files
------------

// File: rtl/nim_board_ctrl.sv
// Board/turn controller for the two-player pile game: cursor, edit and commit driven by
// key strobes, with alternating players and game-over detection.
module nim_board_ctrl #(
    parameter  int CELLS    = 10,
    parameter  int VAL_W    = 4,
    parameter  int INIT_VAL = 1,
    localparam int IDX_W    = $clog2(CELLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_up,
    input  logic                   key_down,
    input  logic                   key_left,
    input  logic                   key_right,
    input  logic                   key_enter,
    input  logic                   key_space,
    input  logic [IDX_W:0]         active_cnt,
    output logic [CELLS*VAL_W-1:0] board,
    output logic [IDX_W-1:0]       cursor,
    output logic [VAL_W-1:0]       edit_val,
    output logic                   player,
    output logic [2:0]             state,
    output logic                   commit_pulse,
    output logic                   game_over,
    output logic                   winner
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_EDIT   = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    localparam logic [IDX_W:0] N_MAX = (IDX_W+1)'(CELLS);

    logic [CELLS-1:0][VAL_W-1:0] piles;
    logic [IDX_W-1:0]            n_last;
    logic [5:0]                  key_now, key_q, key_qq, key_edge;
    logic                        do_space, do_enter, do_left, do_right, do_up, do_down;
    logic                        lr_any;
    logic [IDX_W:0]              n_start;
    logic [VAL_W-1:0]            cur_val;
    logic                        all_zero;

    assign key_now  = {key_space, key_enter, key_left, key_right, key_up, key_down};
    assign key_edge = key_q & ~key_qq;
    assign board    = piles;
    assign cur_val  = piles[cursor];

    // One action per cycle: the highest-priority group with an edge claims it, and a
    // conflicting pair inside a group cancels itself out.
    always_comb begin
        lr_any   = key_edge[3] | key_edge[2];
        do_space = key_edge[5];
        do_enter = key_edge[4] & ~key_edge[5];
        do_left  = ~key_edge[5] & ~key_edge[4] & key_edge[3] & ~key_edge[2];
        do_right = ~key_edge[5] & ~key_edge[4] & key_edge[2] & ~key_edge[3];
        do_up    = ~key_edge[5] & ~key_edge[4] & ~lr_any & key_edge[1] & ~key_edge[0];
        do_down  = ~key_edge[5] & ~key_edge[4] & ~lr_any & key_edge[0] & ~key_edge[1];
    end

    always_comb begin
        if (active_cnt == '0)
            n_start = (IDX_W+1)'(1);
        else if (active_cnt > N_MAX)
            n_start = N_MAX;
        else
            n_start = active_cnt;
    end

    // Board emptiness as it will be after the pending write lands.
    always_comb begin
        all_zero = 1'b1;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (IDX_W'(i) == cursor) begin
                if (edit_val != '0) all_zero = 1'b0;
            end else if (piles[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            key_qq <= '0;
        end else begin
            key_q  <= key_now;
            key_qq <= key_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            piles        <= '0;
            cursor       <= '0;
            edit_val     <= '0;
            player       <= 1'b0;
            commit_pulse <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            n_last       <= '0;
        end else begin
            commit_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (do_enter) begin
                        for (int unsigned i = 0; i < CELLS; i++)
                            piles[i] <= (i < 32'(n_start)) ? VAL_W'(INIT_VAL) : '0;
                        n_last   <= IDX_W'(n_start - 1'b1);
                        cursor   <= '0;
                        edit_val <= '0;
                        player   <= 1'b0;
                        winner   <= 1'b0;
                        state    <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (do_enter) begin
                        if (cur_val != '0) begin
                            edit_val <= cur_val - VAL_W'(1);
                            state    <= S_EDIT;
                        end
                    end else if (do_right) begin
                        cursor <= (cursor == n_last) ? '0 : cursor + IDX_W'(1);
                    end else if (do_left) begin
                        cursor <= (cursor == '0) ? n_last : cursor - IDX_W'(1);
                    end
                end
                S_EDIT: begin
                    if (do_space) begin
                        state <= S_COMMIT;
                    end else if (do_enter) begin
                        state <= S_SELECT;
                    end else if (do_up) begin
                        if (edit_val < cur_val - VAL_W'(1)) edit_val <= edit_val + VAL_W'(1);
                    end else if (do_down) begin
                        if (edit_val != '0) edit_val <= edit_val - VAL_W'(1);
                    end
                end
                S_COMMIT: begin
                    piles[cursor] <= edit_val;
                    commit_pulse  <= 1'b1;
                    player        <= ~player;
                    if (all_zero) begin
                        winner    <= player;
                        game_over <= 1'b1;
                        state     <= S_OVER;
                    end else begin
                        state     <= S_SELECT;
                    end
                end
                S_OVER: begin
                    if (do_enter) begin
                        game_over <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    game_over <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nim_board_ctrl.sv
// Directed bench for nim_board_ctrl: instance a uses INIT_VAL=1, instance b INIT_VAL=5;
// both share the key inputs.
module tb_nim_board_ctrl;

    localparam logic [5:0] K_SP = 6'b100000;
    localparam logic [5:0] K_EN = 6'b010000;
    localparam logic [5:0] K_LF = 6'b001000;
    localparam logic [5:0] K_RT = 6'b000100;
    localparam logic [5:0] K_UP = 6'b000010;
    localparam logic [5:0] K_DN = 6'b000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  keys = '0;
    logic [4:0]  active_cnt = 5'd3;

    logic [39:0] a_board, b_board;
    logic [3:0]  a_cursor, b_cursor, a_ev, b_ev;
    logic        a_player, b_player, a_pulse, b_pulse, a_over, b_over, a_win, b_win;
    logic [2:0]  a_state, b_state;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    nim_board_ctrl u_a (
        .clk(clk), .rst_n(rst_n),
        .key_up(keys[1]), .key_down(keys[0]), .key_left(keys[3]), .key_right(keys[2]),
        .key_enter(keys[4]), .key_space(keys[5]), .active_cnt(active_cnt),
        .board(a_board), .cursor(a_cursor), .edit_val(a_ev), .player(a_player),
        .state(a_state), .commit_pulse(a_pulse), .game_over(a_over), .winner(a_win)
    );

    nim_board_ctrl #(.CELLS(10), .VAL_W(4), .INIT_VAL(5)) u_b (
        .clk(clk), .rst_n(rst_n),
        .key_up(keys[1]), .key_down(keys[0]), .key_left(keys[3]), .key_right(keys[2]),
        .key_enter(keys[4]), .key_space(keys[5]), .active_cnt(active_cnt),
        .board(b_board), .cursor(b_cursor), .edit_val(b_ev), .player(b_player),
        .state(b_state), .commit_pulse(b_pulse), .game_over(b_over), .winner(b_win)
    );

    always @(negedge clk) if (b_pulse) pulse_cnt++;

    typedef struct {
        logic [5:0]  keys;
        logic [2:0]  st;
        logic [3:0]  cur;
        logic [3:0]  ev;
        logic        chk_ev;
        logic        pl;
        logic [39:0] brd;
        int          pulses;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [5:0] k);
        @(negedge clk) keys = k;
        @(negedge clk) keys = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        keys  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        // b runs with n=3 and INIT_VAL=5, starting in SELECT at cursor 0.
        tbl[0]  = '{K_LF,        3'd1, 4'd2, 4'd0, 1'b0, 1'b0, 40'h555, 0};
        tbl[1]  = '{K_RT,        3'd1, 4'd0, 4'd0, 1'b0, 1'b0, 40'h555, 0};
        tbl[2]  = '{K_RT,        3'd1, 4'd1, 4'd0, 1'b0, 1'b0, 40'h555, 0};
        tbl[3]  = '{K_EN,        3'd2, 4'd1, 4'd4, 1'b1, 1'b0, 40'h555, 0};
        tbl[4]  = '{K_UP,        3'd2, 4'd1, 4'd4, 1'b1, 1'b0, 40'h555, 0};
        tbl[5]  = '{K_DN,        3'd2, 4'd1, 4'd3, 1'b1, 1'b0, 40'h555, 0};
        tbl[6]  = '{K_DN,        3'd2, 4'd1, 4'd2, 1'b1, 1'b0, 40'h555, 0};
        tbl[7]  = '{K_DN,        3'd2, 4'd1, 4'd1, 1'b1, 1'b0, 40'h555, 0};
        tbl[8]  = '{K_DN,        3'd2, 4'd1, 4'd0, 1'b1, 1'b0, 40'h555, 0};
        tbl[9]  = '{K_DN,        3'd2, 4'd1, 4'd0, 1'b1, 1'b0, 40'h555, 0};
        tbl[10] = '{K_UP,        3'd2, 4'd1, 4'd1, 1'b1, 1'b0, 40'h555, 0};
        tbl[11] = '{K_EN,        3'd1, 4'd1, 4'd0, 1'b0, 1'b0, 40'h555, 0};
        tbl[12] = '{K_EN,        3'd2, 4'd1, 4'd4, 1'b1, 1'b0, 40'h555, 0};
        tbl[13] = '{K_DN,        3'd2, 4'd1, 4'd3, 1'b1, 1'b0, 40'h555, 0};
        tbl[14] = '{K_DN,        3'd2, 4'd1, 4'd2, 1'b1, 1'b0, 40'h555, 0};
        tbl[15] = '{K_DN,        3'd2, 4'd1, 4'd1, 1'b1, 1'b0, 40'h555, 0};
        tbl[16] = '{K_DN,        3'd2, 4'd1, 4'd0, 1'b1, 1'b0, 40'h555, 0};
        tbl[17] = '{K_SP,        3'd1, 4'd1, 4'd0, 1'b0, 1'b1, 40'h505, 1};
        tbl[18] = '{K_EN,        3'd1, 4'd1, 4'd0, 1'b0, 1'b1, 40'h505, 0};
        tbl[19] = '{K_LF | K_RT, 3'd1, 4'd1, 4'd0, 1'b0, 1'b1, 40'h505, 0};
        tbl[20] = '{K_RT,        3'd1, 4'd2, 4'd0, 1'b0, 1'b1, 40'h505, 0};
        tbl[21] = '{K_RT,        3'd1, 4'd0, 4'd0, 1'b0, 1'b1, 40'h505, 0};

        do_reset();
        check("rst_state", b_state, 3'd0);
        check("rst_board", b_board, 40'h0);
        check("rst_outs", {b_cursor, b_ev, b_player, b_pulse, b_over, b_win}, 12'h0);

        active_cnt = 5'd3;
        press(K_EN);
        check("start_a_state", a_state, 3'd1);
        check("start_a_board", a_board, 40'h111);
        check("start_a_cursor", a_cursor, 4'd0);
        check("start_b_board", b_board, 40'h555);

        for (int i = 0; i < 22; i++) begin
            p0 = pulse_cnt;
            press(tbl[i].keys);
            check($sformatf("v%0d_state", i), b_state, tbl[i].st);
            check($sformatf("v%0d_cursor", i), b_cursor, tbl[i].cur);
            if (tbl[i].chk_ev) check($sformatf("v%0d_edit", i), b_ev, tbl[i].ev);
            check($sformatf("v%0d_player", i), b_player, tbl[i].pl);
            check($sformatf("v%0d_board", i), b_board, tbl[i].brd);
            check($sformatf("v%0d_pulses", i), pulse_cnt - p0, tbl[i].pulses);
        end

        // Held key acts once.
        @(negedge clk) keys = K_RT;
        repeat (100) @(negedge clk);
        keys = '0;
        repeat (3) @(negedge clk);
        check("held_right", b_cursor, 4'd1);

        // Two-pile game on a (INIT_VAL=1), with active_cnt changed mid-game.
        do_reset();
        active_cnt = 5'd2;
        press(K_EN);
        check("g_start", {a_state, a_board}, {3'd1, 40'h11});
        press(K_EN);
        check("g_edit0", {a_state, a_ev}, {3'd2, 4'd0});
        press(K_SP);
        check("g_commit0", {a_state, a_player, a_over, a_board}, {3'd1, 1'b1, 1'b0, 40'h10});
        press(K_RT);
        check("g_right", a_cursor, 4'd1);
        active_cnt = 5'd7;
        press(K_RT);
        check("g_latched_n", a_cursor, 4'd0);
        press(K_RT);
        check("g_right2", a_cursor, 4'd1);
        press(K_EN);
        check("g_edit1", a_state, 3'd2);
        press(K_SP);
        check("g_over", {a_state, a_over, a_win, a_player, a_board}, {3'd4, 1'b1, 1'b1, 1'b0, 40'h0});
        press(K_EN);
        check("g_idle", {a_state, a_over}, {3'd0, 1'b0});

        // Space+enter together in EDIT commits only; then reset drop mid-edit.
        do_reset();
        active_cnt = 5'd3;
        press(K_EN);
        press(K_EN);
        press(K_DN);
        check("se_edit", {b_state, b_ev}, {3'd2, 4'd3});
        p0 = pulse_cnt;
        press(K_SP | K_EN);
        check("se_commit", {b_state, b_player, b_board}, {3'd1, 1'b1, 40'h553});
        check("se_pulses", pulse_cnt - p0, 1);
        press(K_EN);
        check("se_reedit", {b_state, b_ev}, {3'd2, 4'd2});
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid_rst_state", b_state, 3'd0);
        check("mid_rst_board", b_board, 40'h0);
        check("mid_rst_outs", {b_cursor, b_ev, b_player, b_pulse, b_over, b_win}, 12'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
